poly_comp_seq: RTL and testbench
================================

# poly_comp_seq

Horner-scheme polynomial evaluation sequencer for temperature compensation. On `strt` it fetches NUM_COEFF signed Q1.14 coefficients from NV_mem, highest order first. Each step it drives the shared 16x16 saturating multiplier with the accumulator and the latched Temp. It then adds the next coefficient with saturation, producing `comp_out = c0 + T*(c1 + T*(c2 + ...))`. It sits between the coefficient memory, the Temp register and the saturating multiplier, and owns the multiplier's operand inputs.

## Interface
- NUM_COEFF, 4, number of coefficients (polynomial degree + 1), legal range 1..16
- ADDR_W, 4, NV_mem coefficient address width; must satisfy 2^ADDR_W >= NUM_COEFF

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- strt  in  1  start request, sampled on rising edge; honoured only while `rdy`
- Temp  in  16  signed Q1.14 temperature, latched on accepted `strt`
- coeff_rd  out  1  coefficient read strobe (combinational)
- coeff_addr  out  ADDR_W  coefficient address (combinational)
- coeff  in  16  signed coefficient; valid the cycle after `coeff_rd`
- mult_a  out  16  multiplier operand A = accumulator register
- mult_b  out  16  multiplier operand B = latched Temp
- mult_prod  in  16  combinational saturated product, sat((mult_a*mult_b)>>>14)
- rdy  out  1  high in IDLE
- done  out  1  one-cycle completion pulse
- comp_out  out  16  signed saturated result, held until next completion

## Operation
- States: IDLE, FETCH, MAC, DONE.
- IDLE
  - `rdy`=1.
  - On `strt`: drive `coeff_rd`=1 and `coeff_addr`=NUM_COEFF-1, latch Temp into t_reg, load idx=NUM_COEFF-1, go to FETCH.
- FETCH
  - acc <= coeff.
  - If NUM_COEFF==1, go to DONE with comp_out <= coeff.
  - Else drive `coeff_rd`=1 and `coeff_addr`=idx-1, set idx <= idx-1, go to MAC.
- MAC
  - acc <= sat_add(mult_prod, coeff).
  - If idx==0: comp_out <= sat_add(mult_prod, coeff), go to DONE.
  - Else drive `coeff_rd`=1 and `coeff_addr`=idx-1, set idx <= idx-1, stay in MAC.
- DONE: `done`=1 for this cycle only, then go to IDLE.
- `coeff_rd`=0 in every cycle not listed above; `coeff_addr` = 0 when `coeff_rd`=0.
- sat_add: 17-bit signed sum of two 16-bit operands, clamped to 0x7FFF / 0x8000 on overflow. Saturation applies per step, not once at the end.
- `mult_a`/`mult_b` are driven directly from the acc and t_reg registers, so they are glitch-free for the shared multiplier.
- `strt` outside IDLE is ignored, with no queueing. The Temp input is don't-care after latch.
- Reset values: state=IDLE, acc=0, t_reg=0, idx=0, comp_out=0, done=0, rdy=1 (decoded).
- Reset asserted mid-sequence: immediate return to IDLE. No `done` is produced and comp_out is cleared to 0.

## Timing
- Edge E0 samples `strt`. FETCH is the cycle after E0, and the MAC cycles follow for NUM_COEFF-1 cycles.
- comp_out updates on edge E_NUM_COEFF.
- `done` is high during the cycle after E_NUM_COEFF; comp_out is valid there and held.
- `rdy` rises together with the DONE→IDLE transition.
- Throughput: `strt` is accepted at the earliest one cycle after `done`. A new sequence therefore starts every NUM_COEFF+2 cycles.
- Critical path: acc → external multiplier → sat_add → acc, one cycle with no internal pipelining.

## Structure
- Package poly_comp_pkg:
  - state enum typedef (IDLE, FETCH, MAC, DONE)
  - SAT_MAX=16'h7FFF, SAT_MIN=16'h8000
  - Q_FRAC=14
- Sub-module sat_add16: combinational 16+16→16 saturating adder with ports a, b, sum.
- The multiplier stays external so that other controllers can share it.

## Test plan
The bench uses a behavioural multiplier model sat((a*b)>>>14) and a 1-cycle-latency coefficient ROM; NUM_COEFF=4 unless noted.
- Unity T: c3..c0 = 0x1000, 0x0800, 0x0400, 0x0200, Temp=0x4000 → comp_out=0x1E00, `done` exactly 5 edges after `strt`.
- Half T: same coefficients, Temp=0x2000 → comp_out=0x0800. Check the read sequence: addr 3,2,1,0 on consecutive cycles, one `coeff_rd` each.
- Positive saturation: all coeff=0x7000, Temp=0x4000 → comp_out=0x7FFF.
- Negative saturation: all coeff=0x9000, Temp=0x4000 → comp_out=0x8000.
- Control:
  - `strt` pulsed in the FETCH and MAC cycles → ignored, a single `done`, result unchanged.
  - rst_n low during the second MAC → rdy=1, comp_out=0, no `done`.
  - A following `strt` completes normally.
- NUM_COEFF=1: coeff=0x1234 → comp_out=0x1234 with `done` 2 edges after `strt`, and no multiplier-dependent update.

Source files
------------

// File: rtl/poly_comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_comp_pkg
//  Brief    : Shared types and constants for the Horner polynomial sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package poly_comp_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Q1.14 saturation limits
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  // Fractional bits of the coefficient / temperature format
  localparam int Q_FRAC = 14;

  // Clamp a 17-bit signed sum into 16 bits. The top two bits disagree only
  // when the sum left the 16-bit range; bit 16 then carries the true sign.
  function automatic logic [15:0] sat16(input logic [16:0] s);
    logic [15:0] r;
    if (s[16] != s[15]) begin
      r = s[16] ? SAT_MIN : SAT_MAX;
    end else begin
      r = s[15:0];
    end
    return r;
  endfunction

endpackage : poly_comp_pkg
`default_nettype wire

// File: rtl/poly_comp_seq_sat_add16.sv
`default_nettype none
// ============================================================================
//  Module   : sat_add16
//  Brief    : Combinational 16+16 -> 16 signed saturating adder.
//  Revision : 1.0  initial release
// ============================================================================
module sat_add16
  import poly_comp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [16:0] w_wide;

  // Sign-extend both operands so the 17-bit sum can never wrap
  always_comb begin
    w_wide = {a[15], a} + {b[15], b};
    sum    = sat16(w_wide);
  end

endmodule : sat_add16
`default_nettype wire

// File: rtl/poly_comp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : poly_comp_seq
//  Brief    : Horner-scheme polynomial evaluator for temperature
//             compensation. Fetches coefficients highest order first and
//             iterates acc = sat(T*acc + c) through a shared external
//             saturating multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module poly_comp_seq
  import poly_comp_pkg::*;
#(
  parameter int NUM_COEFF = 4,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt,
  input  logic [15:0]       Temp,
  output logic              coeff_rd,
  output logic [ADDR_W-1:0] coeff_addr,
  input  logic [15:0]       coeff,
  output logic [15:0]       mult_a,
  output logic [15:0]       mult_b,
  input  logic [15:0]       mult_prod,
  output logic              rdy,
  output logic              done,
  output logic [15:0]       comp_out
);

  // State encodings, taken from the shared enum so all users agree
  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_fetch = FETCH;
  localparam logic [1:0] c_st_mac   = MAC;
  localparam logic [1:0] c_st_done  = DONE;

  // Address of the highest-order coefficient, fetched first
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_COEFF - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [15:0]       r_acc;
  logic [15:0]       r_treg;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_comp;

  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_sum;
  logic              w_last_mac;

  // Product of the previous accumulator and T plus the coefficient that
  // arrives this cycle
  sat_add16 u_sat_add (
    .a   (mult_prod),
    .b   (coeff),
    .sum (w_sum)
  );

  assign w_last_mac = (r_idx == '0);

  // Coefficient read strobe: next address is requested one cycle ahead of
  // its use because the memory has one cycle of read latency
  always_comb begin
    w_rd   = 1'b0;
    w_addr = '0;
    case (r_state)
      c_st_idle: begin
        if (strt) begin
          w_rd   = 1'b1;
          w_addr = c_last_addr;
        end
      end
      c_st_fetch: begin
        if (NUM_COEFF > 1) begin
          w_rd   = 1'b1;
          w_addr = r_idx - c_addr_one;
        end
      end
      c_st_mac: begin
        if (!w_last_mac) begin
          w_rd   = 1'b1;
          w_addr = r_idx - c_addr_one;
        end
      end
      default: begin
        w_rd   = 1'b0;
        w_addr = '0;
      end
    endcase
  end

  // Sequencer state, accumulator, latched temperature and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_acc   <= '0;
      r_treg  <= '0;
      r_idx   <= '0;
      r_comp  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (strt) begin
            r_treg  <= Temp;
            r_idx   <= c_last_addr;
            r_state <= c_st_fetch;
          end
        end
        c_st_fetch: begin
          r_acc <= coeff;
          if (NUM_COEFF == 1) begin
            // Constant polynomial: the single coefficient is the result
            r_comp  <= coeff;
            r_state <= c_st_done;
          end else begin
            r_idx   <= r_idx - c_addr_one;
            r_state <= c_st_mac;
          end
        end
        c_st_mac: begin
          r_acc <= w_sum;
          if (w_last_mac) begin
            r_comp  <= w_sum;
            r_state <= c_st_done;
          end else begin
            r_idx <= r_idx - c_addr_one;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Outputs: multiplier operands straight from registers, status decoded
  assign coeff_rd   = w_rd;
  assign coeff_addr = w_addr;
  assign mult_a     = r_acc;
  assign mult_b     = r_treg;
  assign rdy        = (r_state == c_st_idle);
  assign done       = (r_state == c_st_done);
  assign comp_out   = r_comp;

endmodule : poly_comp_seq
`default_nettype wire

// File: tb/tb_poly_comp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_comp_seq
//  Brief    : Self-checking bench for poly_comp_seq with a scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_comp_seq;

  localparam int N  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (NUM_COEFF = 4) ----------------
  logic          rst_n;
  logic          strt;
  logic [15:0]   temp;
  logic          coeff_rd;
  logic [AW-1:0] coeff_addr;
  logic [15:0]   coeff;
  logic [15:0]   mult_a, mult_b, mult_prod;
  logic          rdy, done;
  logic [15:0]   comp_out;

  // ---------------- second DUT (NUM_COEFF = 1) -------------
  logic          strt1;
  logic [15:0]   temp1;
  logic          rd1;
  logic [0:0]    addr1;
  logic [15:0]   coeff1;
  logic [15:0]   a1, b1, prod1;
  logic          rdy1, done1;
  logic [15:0]   out1;

  logic [15:0]   rom [N];
  logic [15:0]   rom1;
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural helpers
  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] mulsat(input logic [15:0] a, input logic [15:0] b);
    int ai, bi, p;
    ai = $signed(a);
    bi = $signed(b);
    p  = (ai * bi) >>> 14;
    return 16'(clamp(p));
  endfunction

  // Reference: c0 + T*(c1 + T*(c2 + T*c3)) with saturation at every step
  function automatic logic [15:0] model(input logic [15:0] t);
    int acc, ci, pi;
    acc = $signed(rom[N-1]);
    for (int i = N - 2; i >= 0; i--) begin
      pi  = $signed(mulsat(16'(acc), t));
      ci  = $signed(rom[i]);
      acc = clamp(pi + ci);
    end
    return 16'(acc);
  endfunction

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h4000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Memory models (one cycle read latency) and multiplier models
  always @(posedge clk) coeff  <= coeff_rd ? rom[coeff_addr] : 16'hDEAD;
  always @(posedge clk) coeff1 <= rd1 ? rom1 : 16'hBEEF;
  assign mult_prod = mulsat(mult_a, mult_b);
  assign prod1     = mulsat(a1, b1);
  always @(posedge clk) cyc <= cyc + 1;

  poly_comp_seq #(.NUM_COEFF(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .Temp(temp),
    .coeff_rd(coeff_rd), .coeff_addr(coeff_addr), .coeff(coeff),
    .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod),
    .rdy(rdy), .done(done), .comp_out(comp_out)
  );

  poly_comp_seq #(.NUM_COEFF(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .strt(strt1), .Temp(temp1),
    .coeff_rd(rd1), .coeff_addr(addr1), .coeff(coeff1),
    .mult_a(a1), .mult_b(b1), .mult_prod(prod1),
    .rdy(rdy1), .done(done1), .comp_out(out1)
  );

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int          rd_k;
    int          first_rd;
    bit          hold_pend;
    logic [15:0] hold_val;
    exp_t        e;
    rd_k      = 0;
    first_rd  = 0;
    hold_pend = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_k      = 0;
        hold_pend = 1'b0;
        tests++;
        if (rdy !== 1'b1 || done !== 1'b0 || comp_out !== 16'h0 || coeff_rd !== 1'b0) begin
          fails++;
          $display("FAIL reset_state: rdy=%b done=%b comp_out=%h rd=%b, want 1 0 0000 0",
                   rdy, done, comp_out, coeff_rd);
        end
      end else begin
        if (hold_pend && !done) begin
          tests++;
          if (comp_out !== hold_val || rdy !== 1'b1) begin
            fails++;
            $display("FAIL hold: comp_out=%h rdy=%b, want %h 1", comp_out, rdy, hold_val);
          end
          hold_pend = 1'b0;
        end
        if (coeff_rd) begin
          if (rd_k == 0) first_rd = cyc;
          tests++;
          if (coeff_addr !== AW'(N - 1 - rd_k) || cyc != first_rd + rd_k) begin
            fails++;
            $display("FAIL rd_seq: addr=%0d cyc_off=%0d, want addr=%0d cyc_off=%0d",
                     coeff_addr, cyc - first_rd, N - 1 - rd_k, rd_k);
          end
          rd_k++;
        end
        if (done) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: comp_out=%h, want no done", comp_out);
          end else begin
            e = exp_q.pop_front();
            if (comp_out !== e.res || (cyc - e.cyc) != N || rd_k != N) begin
              fails++;
              $display("FAIL result: comp_out=%h lat=%0d reads=%0d, want %h lat=%0d reads=%0d",
                       comp_out, cyc - e.cyc, rd_k, e.res, N, N);
            end
            hold_val  = e.res;
            hold_pend = 1'b1;
          end
          rd_k = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rdy();
    int k = 0;
    while (rdy !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: pending=%0d, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Launch one evaluation; poke keeps strt high through FETCH and MAC1
  task automatic launch(input logic [15:0] c3, input logic [15:0] c2,
                        input logic [15:0] c1, input logic [15:0] c0,
                        input logic [15:0] t, input bit poke);
    exp_t e;
    wait_rdy();
    rom[3] = c3; rom[2] = c2; rom[1] = c1; rom[0] = c0;
    temp = t;
    strt = 1'b1;
    @(posedge clk); #1;
    e.res = model(t);
    e.cyc = cyc;
    exp_q.push_back(e);
    temp = 16'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      temp = 16'($urandom);
      @(posedge clk); #1;
    end
    strt = 1'b0;
  endtask

  initial begin : stimulus
    int e1;
    rst_n = 1'b0;
    strt  = 1'b0;
    strt1 = 1'b0;
    temp  = '0;
    temp1 = '0;
    rom1  = 16'h1234;
    for (int i = 0; i < N; i++) rom[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (mult_a !== 16'h0 || mult_b !== 16'h0 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_regs: a=%h b=%h rdy1=%b, want 0000 0000 1", mult_a, mult_b, rdy1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    launch(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h4000, 1'b0); wait_drain();
    launch(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h2000, 1'b0); wait_drain();
    launch(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h4000, 1'b0); wait_drain();
    launch(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h4000, 1'b0); wait_drain();
    launch(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h4000, 1'b1); wait_drain();

    // Reset during the second MAC cycle: no done, result cleared
    launch(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h4000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    launch(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h2000, 1'b0); wait_drain();

    // Randomised sequences
    for (int n = 0; n < 24; n++) begin
      launch(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
             ($urandom_range(0, 3) == 0));
      wait_drain();
    end

    // Single-coefficient instance
    temp1 = 16'h4000;
    strt1 = 1'b1;
    #1;
    tests++;
    if (rd1 !== 1'b1 || addr1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_read: rd=%b addr=%0d, want 1 0", rd1, addr1);
    end
    @(posedge clk); #1;
    strt1 = 1'b0;
    temp1 = 16'($urandom);
    tests++;
    if (rd1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_fetch: rd=%b done=%b, want 0 0", rd1, done1);
    end
    e1 = 0;
    while (done1 !== 1'b1 && e1 < 20) begin
      @(posedge clk); #1;
      e1++;
    end
    tests++;
    if (done1 !== 1'b1 || e1 != 1 || out1 !== 16'h1234) begin
      fails++;
      $display("FAIL n1_result: done=%b edges=%0d out=%h, want 1 1 1234", done1, e1, out1);
    end
    @(posedge clk); #1;
    tests++;
    if (done1 !== 1'b0 || rdy1 !== 1'b1 || out1 !== 16'h1234) begin
      fails++;
      $display("FAIL n1_after: done=%b rdy=%b out=%h, want 0 1 1234", done1, rdy1, out1);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_poly_comp_seq
`default_nettype wire
